// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared opcode, operand, result and instruction word types
package instr_register_pkg;
  localparam int OPERAND_W = 32;
  localparam int DEF_REGS = 32;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef logic signed [2*OPERAND_W-1:0] result_t;
  typedef logic [$clog2(DEF_REGS)-1:0] address_t;
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
  } instruction_t;
endpackage

// File: rtl/instr_alu.sv
// instr_alu: combinational signed opcode/operand to double-width result
// Ports: opcode, a, b (signed OP_W) in; result (signed 2*OP_W) out.
// DIV/MOD by zero yield 0.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_W = OPERAND_W
) (
  input  opcode_t                  opcode,
  input  logic signed [OP_W-1:0]   a,
  input  logic signed [OP_W-1:0]   b,
  output logic signed [2*OP_W-1:0] result
);
  logic signed [2*OP_W-1:0] xa, xb;
  assign xa = {{OP_W{a[OP_W-1]}}, a};
  assign xb = {{OP_W{b[OP_W-1]}}, b};
  always_comb begin
    result = '0;
    case (opcode)
      PASSA:   result = xa;
      PASSB:   result = xb;
      ADD:     result = xa + xb;
      SUB:     result = xa - xb;
      MULT:    result = xa * xb;
      DIV:     result = (b == '0) ? '0 : xa / xb;
      MOD:     result = (b == '0) ? '0 : xa % xb;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/instr_register_hs.sv
// instr_register_hs: parametrised instruction register with valid/ready registered read port
// Ports: clk, reset (async, active-high); write port load_en/opcode/operand_a/operand_b/write_pointer;
// clear_en invalidates all slots; read port rd_req/read_pointer/rd_ready -> rd_valid/instruction_word/rd_err,
// rd_accept; valid_count = number of valid slots.
// Option: define INSTR_REG_BYPASS_EN to forward a same-cycle write to a read of the same slot.
// OP_W must equal the package OPERAND_W because instruction_word uses the package struct.
module instr_register_hs
  import instr_register_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int OP_W = OPERAND_W,
  parameter int PTR_W = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  opcode_t               opcode,
  input  logic signed [OP_W-1:0] operand_a,
  input  logic signed [OP_W-1:0] operand_b,
  input  logic [PTR_W-1:0]      write_pointer,
  input  logic                  clear_en,
  input  logic                  rd_req,
  input  logic [PTR_W-1:0]      read_pointer,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output instruction_t          instruction_word,
  output logic                  rd_err,
  output logic                  rd_accept,
  output logic [PTR_W:0]        valid_count
);
  instruction_t mem [NUM_REGS];
  logic [NUM_REGS-1:0] valid, valid_nxt;
  logic [PTR_W:0] cnt_nxt;
  logic signed [2*OP_W-1:0] alu_res;
  instruction_t wr_word, rd_word;
  logic rd_bad;
  instr_alu #(.OP_W(OP_W)) u_alu (
    .opcode(opcode),
    .a(operand_a),
    .b(operand_b),
    .result(alu_res)
  );
  assign wr_word = '{opc: opcode, op_a: operand_a, op_b: operand_b, result: alu_res};
  assign rd_accept = rd_req && (!rd_valid || rd_ready);
`ifdef INSTR_REG_BYPASS_EN
  logic hit;
  assign hit = load_en && (write_pointer == read_pointer);
  assign rd_word = hit ? wr_word : mem[read_pointer];
  assign rd_bad = !hit && !valid[read_pointer];
`else
  assign rd_word = mem[read_pointer];
  assign rd_bad = !valid[read_pointer];
`endif
  // a write in the same cycle as a clear keeps its own slot valid
  always_comb begin
    valid_nxt = clear_en ? '0 : valid;
    if (load_en) valid_nxt[write_pointer] = 1'b1;
  end
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) cnt_nxt = cnt_nxt + {{PTR_W{1'b0}}, valid_nxt[i]};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      valid <= '0;
      valid_count <= '0;
    end else begin
      if (load_en) mem[write_pointer] <= wr_word;
      valid <= valid_nxt;
      valid_count <= cnt_nxt;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      instruction_word <= '0;
      rd_err <= 1'b0;
    end else if (rd_accept) begin
      rd_valid <= 1'b1;
      instruction_word <= rd_word;
      rd_err <= rd_bad;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instr_register_hs.sv
// tb_instr_register_hs: directed self-checking bench for instr_register_hs
module tb_instr_register_hs;
  import instr_register_pkg::*;
  logic clk = 1'b0;
  logic reset, load_en, clear_en, rd_req, rd_ready;
  opcode_t opcode;
  logic signed [31:0] operand_a, operand_b;
  logic [4:0] write_pointer, read_pointer;
  logic rd_valid, rd_err, rd_accept;
  instruction_t instruction_word;
  logic [5:0] valid_count;
  int n_cmp = 0;
  int n_err = 0;
  instruction_t w_add, w_div, w_mul, w_pa, w_sub, w_pb;
  instr_register_hs dut (
    .clk(clk),
    .reset(reset),
    .load_en(load_en),
    .opcode(opcode),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .write_pointer(write_pointer),
    .clear_en(clear_en),
    .rd_req(rd_req),
    .read_pointer(read_pointer),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .instruction_word(instruction_word),
    .rd_err(rd_err),
    .rd_accept(rd_accept),
    .valid_count(valid_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic instruction_t iw(opcode_t o, logic signed [31:0] a, logic signed [31:0] b,
                                      logic signed [63:0] r);
    iw = '{o, a, b, r};
  endfunction
  task automatic wr(input opcode_t op, input int a, input int b, input int p);
    @(negedge clk);
    load_en = 1'b1;
    opcode = op;
    operand_a = a;
    operand_b = b;
    write_pointer = p[4:0];
    @(negedge clk);
    load_en = 1'b0;
  endtask
  task automatic rd(input string tag, input int p, input instruction_t w, input logic err);
    @(negedge clk);
    rd_req = 1'b1;
    read_pointer = p[4:0];
    rd_ready = 1'b1;
    #1 check({tag, "_acc"}, rd_accept, 1);
    @(negedge clk);
    rd_req = 1'b0;
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_word"}, instruction_word, w);
    check({tag, "_err"}, rd_err, err);
  endtask
  initial begin
    w_add = iw(ADD, 7, -3, 64'sd4);
    w_div = iw(DIV, 9, 0, 64'sd0);
    w_mul = iw(MULT, 32'h7FFF_FFFF, 2, 64'h0000_0000_FFFF_FFFE);
    w_pa  = iw(PASSA, 1, 5, 64'sd1);
    w_sub = iw(SUB, 10, 4, 64'sd6);
    w_pb  = iw(PASSB, 0, -2, -64'sd2);
    reset = 1'b1;
    {load_en, clear_en, rd_req, rd_ready} = '0;
    opcode = ZERO;
    operand_a = '0;
    operand_b = '0;
    write_pointer = '0;
    read_pointer = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", rd_valid, 0);
    check("rst_word", instruction_word, 0);
    check("rst_err", rd_err, 0);
    check("rst_count", valid_count, 0);
    reset = 1'b0;
    rd("empty5", 5, '0, 1'b1);
    check("empty_count", valid_count, 0);
    @(negedge clk);
    check("drop_valid", rd_valid, 0);
    wr(ADD, 7, -3, 2);
    check("add_count", valid_count, 1);
    rd("add2", 2, w_add, 1'b0);
    wr(DIV, 9, 0, 1);
    wr(MULT, 32'h7FFF_FFFF, 2, 3);
    check("three_count", valid_count, 3);
    rd("div1", 1, w_div, 1'b0);
    rd("mul3", 3, w_mul, 1'b0);
    @(negedge clk);
    rd_req = 1'b1;
    read_pointer = 5'd2;
    rd_ready = 1'b0;
    #1 check("stall_acc0", rd_accept, 1);
    @(negedge clk);
    read_pointer = 5'd1;
    #1 check("stall_valid", rd_valid, 1);
    check("stall_word", instruction_word, w_add);
    check("stall_acc", rd_accept, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("hold_word", instruction_word, w_add);
      check("hold_valid", rd_valid, 1);
      check("hold_acc", rd_accept, 0);
    end
    rd_ready = 1'b1;
    #1 check("release_acc", rd_accept, 1);
    @(negedge clk);
    rd_req = 1'b0;
    check("b2b_valid", rd_valid, 1);
    check("b2b_word", instruction_word, w_div);
    @(negedge clk);
    check("b2b_drop", rd_valid, 0);
    wr(PASSA, 1, 5, 6);
    check("pa_count", valid_count, 4);
    @(negedge clk);
    load_en = 1'b1;
    opcode = SUB;
    operand_a = 10;
    operand_b = 4;
    write_pointer = 5'd6;
    rd_req = 1'b1;
    read_pointer = 5'd6;
    rd_ready = 1'b1;
    #1 check("same_acc", rd_accept, 1);
    @(negedge clk);
    load_en = 1'b0;
    rd_req = 1'b0;
`ifdef INSTR_REG_BYPASS_EN
    check("same_word", instruction_word, w_sub);
`else
    check("same_word", instruction_word, w_pa);
`endif
    check("same_err", rd_err, 0);
    check("rewrite_count", valid_count, 4);
    rd("sub6", 6, w_sub, 1'b0);
    @(negedge clk);
    clear_en = 1'b1;
    load_en = 1'b1;
    opcode = PASSB;
    operand_a = 0;
    operand_b = -2;
    write_pointer = 5'd0;
    rd_req = 1'b1;
    read_pointer = 5'd3;
    rd_ready = 1'b1;
    @(negedge clk);
    {clear_en, load_en, rd_req} = '0;
    check("clr_count", valid_count, 1);
    check("clr_read_word", instruction_word, w_mul);
    check("clr_read_err", rd_err, 0);
    rd("cleared3", 3, w_mul, 1'b1);
    rd("pb0", 0, w_pb, 1'b0);
    @(negedge clk);
    rd_req = 1'b1;
    read_pointer = 5'd0;
    rd_ready = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    check("pre_rst_valid", rd_valid, 1);
    #2 reset = 1'b1;
    #1 check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_word", instruction_word, 0);
    check("mid_rst_count", valid_count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_valid", rd_valid, 0);
    rd("post_rst0", 0, '0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
